// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execution block and the ALU control decoder:
//   - XLEN_DEFAULT : default operand/result width
//   - ALU_*        : 4-bit ALUfunction operation codes
//   - alu_state_e  : execution FSM states
//   - is_shift_op  : true for the three shift codes
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// -----------------------------------------------------------------------------
// alu_seq_shifter
// Bit-serial shift engine: shifts a work register by one bit per step.
// Used only when ALU_BARREL_SHIFT_EN is not defined.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   load_i      capture data_i / shamt_i / op_i (takes priority over step_i)
//   step_i      advance one bit while the remaining count is non-zero
//   data_i      value to be shifted
//   shamt_i     shift amount (expected non-zero when loaded)
//   op_i        ALU_SLL, ALU_SRL or ALU_SRA
//   next_o      work register after one more step (combinational)
//   last_o      the coming step is the final one; next_o is then the result
// -----------------------------------------------------------------------------
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [3:0]         op_i,
  output logic [XLEN-1:0]    next_o,
  output logic               last_o
);

  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [3:0]         op_q, op_d;

  always_comb begin
    case (op_q)
      ALU_SLL: next_o = work_q << 1;
      ALU_SRL: next_o = work_q >> 1;
      default: next_o = {work_q[XLEN-1], work_q[XLEN-1:1]};  // SRA: replicate MSB
    endcase
  end

  // The result is taken together with the final step, so a shift by N
  // completes in N steps rather than N+1.
  assign last_o = (count_q == SHAMT_W'(1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    work_d  = work_q;
    count_d = count_q;
    op_d    = op_q;
    if (load_i) begin
      work_d  = data_i;
      count_d = shamt_i;
      op_d    = op_i;
    end else if (step_i && (count_q != '0)) begin
      work_d  = next_o;
      count_d = count_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      work_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
    end else begin
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// -----------------------------------------------------------------------------
// alu_seq_exec
// Execution-side ALU: accepts operands and a 4-bit ALUfunction code through a
// valid/ready handshake and returns a registered result with zero and illegal
// flags through a second valid/ready handshake.
// Logic, add/sub and compares complete in one cycle. Shifts run bit-serially
// (one bit per cycle) unless the ALU_BARREL_SHIFT_EN macro is defined, in
// which case they are single-cycle barrel shifts. Results are identical in
// both builds; only timing differs.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   in_valid      operands/op presented
//   in_ready      block can accept (IDLE only)
//   ALUfunction   operation code (alu_pkg::ALU_*)
//   a, b          operands; shift amount is b[SHAMT_W-1:0]
//   out_valid     result valid, held until out_ready
//   out_ready     downstream accepts result
//   result        registered result
//   zero          result == 0
//   illegal       code not in the encoding table (result 0, zero 1)
// -----------------------------------------------------------------------------
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUfunction,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               alu_ill;

  assign shamt = b[SHAMT_W-1:0];

  // Single-cycle datapath, evaluated on the operands presented in IDLE.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUfunction)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
`else
      // Serial build reaches this path only for a zero shift amount.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
`endif
      default:  alu_ill = 1'b1;
    endcase
  end

`ifndef ALU_BARREL_SHIFT_EN
  logic            shift_load;
  logic            shift_last;
  logic [XLEN-1:0] shift_next;

  alu_seq_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load_i  (shift_load),
    .step_i  (state_q == SHIFT),
    .data_i  (a),
    .shamt_i (shamt),
    .op_i    (ALUfunction),
    .next_o  (shift_next),
    .last_o  (shift_last)
  );
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    shift_load = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift_op(ALUfunction) && (shamt != '0)) begin
            shift_load = 1'b1;
            state_d    = SHIFT;
          end else
`endif
          begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
        if (shift_last) begin
          result_d  = shift_next;
          zero_d    = (shift_next == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_exec
// Directed bench for alu_seq_exec. Expected results are pushed to a scoreboard
// queue when an operation is accepted and popped when out_valid is observed.
// Outputs are sampled on the falling clock edge; inputs change on the falling
// edge or just after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_seq_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUfunction;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_seq_exec #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALUfunction (ALUfunction),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the operation table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = y[4:0];
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0011: return (x < y) ? 32'd1 : 32'd0;
      4'b0100: return x ^ y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: return x << sh;
      4'b1001: return x >> sh;
      4'b1010: return $signed(x) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] y);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'b1000 || op == 4'b1001 || op == 4'b1010) && y[4:0] != 5'd0)
      return 1 + int'(y[4:0]);
    return 1;
`endif
  endfunction

  // Present one operation in IDLE; returns just after the accepting edge.
  task automatic send(input string tag, input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp_res, input bit track);
    exp_t e;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    ALUfunction = op;
    a           = x;
    b           = y;
    in_valid    = 1'b1;
    if (track) begin
      e.tag  = tag;
      e.res  = exp_res;
      e.zero = (exp_res == 32'd0);
      e.ill  = ~legal(op);
      e.lat  = exp_lat(op, y);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; they must have no effect.
    in_valid    = 1'b0;
    a           = $urandom;
    b           = $urandom;
    ALUfunction = 4'($urandom);
  endtask

  // Wait for out_valid, compare against the scoreboard, optionally stall.
  task automatic collect(input int hold);
    exp_t        e;
    int          lat = 0;
    bit          got = 1'b0;
    logic [31:0] r0;
    logic        z0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("out_valid_seen", 32'(got), 32'd1);
    check("scoreboard_nonempty", 32'(sb.size() != 0), 32'd1);
    if (got && sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "/result"},  result,           e.res);
      check({e.tag, "/zero"},    32'(zero),        32'(e.zero));
      check({e.tag, "/illegal"}, 32'(illegal),     32'(e.ill));
      check({e.tag, "/latency"}, 32'(lat),         32'(e.lat));
      r0 = result;
      z0 = zero;
      for (int i = 0; i < hold; i++) begin
        // Offer a different op while stalled; it must not be taken.
        in_valid    = 1'b1;
        ALUfunction = ALU_ADD;
        a           = 32'd100;
        b           = 32'd200;
        @(negedge clk);
        check({e.tag, "/hold_result"},    result,          r0);
        check({e.tag, "/hold_zero"},      32'(zero),       32'(z0));
        check({e.tag, "/hold_in_ready"},  32'(in_ready),   32'd0);
        check({e.tag, "/hold_out_valid"}, 32'(out_valid),  32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({e.tag, "/drop_out_valid"}, 32'(out_valid), 32'd0);
      check({e.tag, "/back_in_ready"},  32'(in_ready),  32'd1);
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    ALUfunction = 4'd0;
    a           = 32'd0;
    b           = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/in_ready",  32'(in_ready),  32'd1);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/result",    result,         32'd0);
    check("rst/zero",      32'(zero),      32'd0);
    check("rst/illegal",   32'(illegal),   32'd0);
    reset = 1'b0;

    // Spec vectors with constant expectations.
    send("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1); collect(0);
    send("sub_eq",  ALU_SUB, 32'd5, 32'd5, 32'd0, 1'b1);                 collect(0);
    send("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1);         collect(0);
    send("sltu_big", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);       collect(0);
    send("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b1);    collect(0);
    send("sll_sh0", ALU_SLL, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b1); collect(0);
    send("ill_f", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1);   collect(0);

    // Additional patterns checked against the reference model.
    send("and",   ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, ref_alu(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00), 1'b1); collect(0);
    send("or",    ALU_OR,  32'hA000_0001, 32'h0500_0010, ref_alu(ALU_OR,  32'hA000_0001, 32'h0500_0010), 1'b1); collect(0);
    send("sub_wrap", ALU_SUB, 32'd0, 32'd1, ref_alu(ALU_SUB, 32'd0, 32'd1), 1'b1);                              collect(0);
    send("slt_pos", ALU_SLT, 32'd3, 32'hFFFF_FFFE, ref_alu(ALU_SLT, 32'd3, 32'hFFFF_FFFE), 1'b1);              collect(0);
    send("srl1",  ALU_SRL, 32'h8000_0003, 32'd1, ref_alu(ALU_SRL, 32'h8000_0003, 32'd1), 1'b1);                collect(0);
    send("sll31", ALU_SLL, 32'h0000_0003, 32'h0000_00FF, ref_alu(ALU_SLL, 32'h3, 32'hFF), 1'b1);               collect(0);
    send("sra31", ALU_SRA, 32'h8000_0000, 32'd31, ref_alu(ALU_SRA, 32'h8000_0000, 32'd31), 1'b1);              collect(0);
    send("srl_zero", ALU_SRL, 32'h0000_0010, 32'd5, ref_alu(ALU_SRL, 32'h10, 32'd5), 1'b1);                    collect(0);
    send("ill_5", 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);                                          collect(0);

    // Backpressure: result held 10 cycles with a competing request offered.
    send("xor_hold", ALU_XOR, 32'hFFFF_0000, 32'h00FF_FF00, ref_alu(ALU_XOR, 32'hFFFF_0000, 32'h00FF_FF00), 1'b1);
    collect(10);
    repeat (3) begin
      @(negedge clk);
      check("post_hold/out_valid", 32'(out_valid), 32'd0);
    end

    // Reset two cycles into a long serial shift discards the operation.
    send("srl20_abort", ALU_SRL, 32'hFFFF_FFFF, 32'd20, 32'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort/in_ready",  32'(in_ready),  32'd1);
    check("abort/out_valid", 32'(out_valid), 32'd0);
    check("abort/result",    result,         32'd0);
    check("abort/zero",      32'(zero),      32'd0);
    check("abort/illegal",   32'(illegal),   32'd0);
    repeat (25) begin
      @(negedge clk);
      check("abort/no_out_valid", 32'(out_valid), 32'd0);
    end

    send("add_after", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b1);
    collect(0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
